// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer for the 3-bus datapath.
// Each instruction is fetched (T0-T2) and then executed (T3-T7). The
// control strobes depend only on the current state and the IR opcode.
// Memory reads and writes stay asserted until mem_done arrives. A bounded
// wait counter sends the sequencer to HALT if memory never answers.
module control_sequencer #(
    parameter int REG_SIZE    = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [REG_SIZE-1:0] ir,
    input  logic                mem_done,
    output logic                gra,
    output logic                grb,
    output logic                grc,
    output logic                r_in,
    output logic                r_out,
    output logic                ba_out,
    output logic                pc_out,
    output logic                pc_in,
    output logic                inc_pc,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlo_out,
    output logic                c_out,
    output logic [3:0]          alu_op,
    output logic                read,
    output logic                write,
    output logic                mem_src,
    output logic                halted,
    output logic                illegal,
    output logic                mem_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_INC = 4'd4;

    logic [3:0]       state;
    logic [3:0]       next_state;
    logic [3:0]       end_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic [4:0]       opcode;
    logic             ir_unused;
    logic             is_rtype;
    logic             is_itype;
    logic             is_ldi;
    logic             is_ld;
    logic             is_st;
    logic             is_halt;
    logic             is_known;
    logic [3:0]       exec_alu;
    logic             mem_wait;
    logic             at_limit;
    logic             timeout;

    // Only the opcode field steers the sequencer. The register fields are decoded downstream.
    assign opcode    = ir[REG_SIZE-1 -: 5];
    assign ir_unused = ^ir[REG_SIZE-6:0];

    assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
    assign is_itype = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_ldi   = (opcode == OP_LDI);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_halt  = (opcode == OP_HALT);
    assign is_known = is_rtype || is_itype || is_ldi || is_ld || is_st || is_halt ||
                      (opcode == OP_NOP);

    // ALU operation used in T4. Loads and stores use ADD to form the address.
    always_comb begin
        exec_alu = ALU_ADD;
        case (opcode)
            OP_SUB:          exec_alu = ALU_SUB;
            OP_AND, OP_ANDI: exec_alu = ALU_AND;
            OP_OR,  OP_ORI:  exec_alu = ALU_OR;
            default:         exec_alu = ALU_ADD;
        endcase
    end

    // Memory wait bookkeeping. The counter is zero in the first cycle of every wait state.
    assign mem_wait = (state == S_T1) || ((state == S_T6) && is_ld) ||
                      ((state == S_T7) && is_st);
    assign at_limit = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign timeout  = mem_wait && !mem_done && at_limit;
    assign next_cnt = (mem_wait && !mem_done && !at_limit) ? wait_cnt + 1'b1 : '0;
    assign end_state = run ? S_T0 : S_IDLE;

    // Next-state sequencing through fetch, execute and the memory handshakes
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: next_state = run ? S_T0 : S_IDLE;
            S_T0:   next_state = S_T1;
            S_T1: begin
                if (mem_done)     next_state = S_T2;
                else if (timeout) next_state = S_HALT;
            end
            S_T2:   next_state = S_T3;
            S_T3: begin
                if (is_halt)
                    next_state = S_HALT;
                else if (is_rtype || is_itype || is_ldi || is_ld || is_st)
                    next_state = S_T4;
                else
                    next_state = end_state;
            end
            S_T4:   next_state = S_T5;
            S_T5:   next_state = (is_ld || is_st) ? S_T6 : end_state;
            S_T6: begin
                if (!is_ld)       next_state = S_T7;
                else if (mem_done) next_state = S_T7;
                else if (timeout)  next_state = S_HALT;
            end
            S_T7: begin
                if (!is_st)        next_state = end_state;
                else if (mem_done) next_state = end_state;
                else if (timeout)  next_state = S_HALT;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    // State, wait counter and sticky memory-timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            if (timeout) mem_err <= 1'b1;
        end
    end

    // Moore output decode from the current state and the opcode
    always_comb begin
        gra = 1'b0; grb = 1'b0; grc = 1'b0;
        r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
        pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0;
        mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
        y_in = 1'b0; z_in = 1'b0; zlo_out = 1'b0; c_out = 1'b0;
        alu_op = ALU_ADD;
        read = 1'b0; write = 1'b0; mem_src = 1'b0;
        halted = 1'b0; illegal = 1'b0;
        case (state)
            S_T0: begin
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
                alu_op = ALU_INC;
            end
            S_T1: begin
                zlo_out = 1'b1; read = 1'b1; mem_src = 1'b1; mdr_in = 1'b1;
                pc_in   = (wait_cnt == '0);
            end
            S_T2: begin
                mdr_out = 1'b1; ir_in = 1'b1;
            end
            S_T3: begin
                if (is_rtype || is_itype) begin
                    grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
                end
                illegal = !is_known;
            end
            S_T4: begin
                if (is_rtype) begin
                    grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = exec_alu;
                end else if (is_itype || is_ldi || is_ld || is_st) begin
                    c_out = 1'b1; z_in = 1'b1; alu_op = exec_alu;
                end
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (is_ld || is_st) mar_in = 1'b1;
                else begin
                    gra = 1'b1; r_in = 1'b1;
                end
            end
            S_T6: begin
                mdr_in = 1'b1;
                if (is_ld) begin
                    read = 1'b1; mem_src = 1'b1;
                end else begin
                    gra = 1'b1; r_out = 1'b1;
                end
            end
            S_T7: begin
                if (is_st) write = 1'b1;
                else if (is_ld) begin
                    mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer.
// Stimulus pushes the expected control word for each cycle into a queue.
// A monitor pops each word and compares it with the DUT outputs on the falling edge.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        mem_done = 1'b0;
    logic gra, grb, grc, r_in, r_out, ba_out, pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlo_out, c_out;
    logic [3:0] alu_op;
    logic read, write, mem_src, halted, illegal, mem_err;

    typedef struct {
        logic [26:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t sb[$];
    int pass_count = 0;
    int check_count = 0;

    localparam logic [26:0] GRA = 27'd1 << 0,  GRB = 27'd1 << 1,  GRC = 27'd1 << 2;
    localparam logic [26:0] RIN = 27'd1 << 3,  ROUT = 27'd1 << 4, BAOUT = 27'd1 << 5;
    localparam logic [26:0] PCOUT = 27'd1 << 6, PCIN = 27'd1 << 7, INCPC = 27'd1 << 8;
    localparam logic [26:0] MARIN = 27'd1 << 9, MDRIN = 27'd1 << 10, MDROUT = 27'd1 << 11;
    localparam logic [26:0] IRIN = 27'd1 << 12, YIN = 27'd1 << 13, ZIN = 27'd1 << 14;
    localparam logic [26:0] ZLO = 27'd1 << 15, COUT = 27'd1 << 16, READ = 27'd1 << 17;
    localparam logic [26:0] WRITE = 27'd1 << 18, MEMSRC = 27'd1 << 19, HALTED = 27'd1 << 20;
    localparam logic [26:0] ILLEGAL = 27'd1 << 21, MEMERR = 27'd1 << 22;

    localparam logic [31:0] I_ADD  = 32'h1989_0000;
    localparam logic [31:0] I_LD   = 32'h0088_0000;
    localparam logic [31:0] I_LDI  = 32'h0888_0000;
    localparam logic [31:0] I_ST   = 32'h1088_0000;
    localparam logic [31:0] I_SUB  = 32'h2189_0000;
    localparam logic [31:0] I_OR   = 32'h3189_0000;
    localparam logic [31:0] I_ADDI = 32'h6088_0000;
    localparam logic [31:0] I_ANDI = 32'h6888_0000;
    localparam logic [31:0] I_ORI  = 32'h7088_0000;
    localparam logic [31:0] I_NOP  = 32'hC000_0000;
    localparam logic [31:0] I_HALT = 32'hD800_0000;
    localparam logic [31:0] I_BAD  = 32'hF800_0000;

    localparam logic [26:0] E_T0  = PCOUT | MARIN | INCPC | ZIN | {4'd4, 23'd0};
    localparam logic [26:0] E_T1F = ZLO | PCIN | READ | MEMSRC | MDRIN;
    localparam logic [26:0] E_T1W = ZLO | READ | MEMSRC | MDRIN;
    localparam logic [26:0] E_T2  = MDROUT | IRIN;
    localparam logic [26:0] E_R3  = GRB | ROUT | YIN;
    localparam logic [26:0] E_B3  = GRB | BAOUT | YIN;
    localparam logic [26:0] E_WB5 = ZLO | GRA | RIN;
    localparam logic [26:0] E_A5  = ZLO | MARIN;

    logic [26:0] actual;
    assign actual = {alu_op, mem_err, illegal, halted, mem_src, write, read, c_out, zlo_out,
                     z_in, y_in, ir_in, mdr_out, mdr_in, mar_in, inc_pc, pc_in, pc_out,
                     ba_out, r_out, r_in, grc, grb, gra};

    control_sequencer #(.REG_SIZE(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .ir(ir), .mem_done(mem_done),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .zlo_out(zlo_out), .c_out(c_out), .alu_op(alu_op), .read(read), .write(write),
        .mem_src(mem_src), .halted(halted), .illegal(illegal), .mem_err(mem_err)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    function automatic logic [26:0] alu(input logic [3:0] op);
        return {op, 23'd0};
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue that cycle's expected outputs
    task automatic applyStimulus(input logic rst_v, input logic [31:0] ir_v, input logic run_v,
                                 input logic md_v, input logic [26:0] exp, input string name);
        @(posedge clk);
        #1;
        reset_n  = rst_v;
        ir       = ir_v;
        run      = run_v;
        mem_done = md_v;
        sb.push_back('{exp, name});
    endtask

    // Fetch sequence with a given number of extra T1 wait cycles
    task automatic fetch(input logic [31:0] ir_v, input int waits);
        applyStimulus(1'b1, ir_v, 1'b1, 1'b0, E_T0, "T0");
        applyStimulus(1'b1, ir_v, 1'b1, waits == 0, E_T1F, "T1_first");
        for (int i = 0; i < waits; i++)
            applyStimulus(1'b1, ir_v, 1'b1, i == waits - 1, E_T1W, "T1_wait");
        applyStimulus(1'b1, ir_v, 1'b1, 1'b0, E_T2, "T2");
    endtask

    // Complete register or immediate ALU instruction after fetch
    task automatic aluInstr(input logic [31:0] ir_v, input logic imm, input logic [3:0] op,
                            input logic run_end);
        fetch(ir_v, 0);
        applyStimulus(1'b1, ir_v, 1'b1, 1'b0, E_R3, "exec_T3");
        if (imm) applyStimulus(1'b1, ir_v, 1'b1, 1'b0, COUT | ZIN | alu(op), "imm_T4");
        else     applyStimulus(1'b1, ir_v, 1'b1, 1'b0, GRC | ROUT | ZIN | alu(op), "reg_T4");
        applyStimulus(1'b1, ir_v, run_end, 1'b0, E_WB5, "wb_T5");
    endtask

    // Compare a popped expected word against the DUT outputs
    task automatic checkOutput(input sb_item_t item);
        check_count++;
        if (actual === item.exp) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h", item.name, actual, item.exp);
    endtask

    // Monitor pops the scoreboard on every falling edge that has a pending expectation
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        // Reset state, then leave IDLE with run raised
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 27'd0, "reset_idle");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 27'd0, "reset_run_ignored");
        applyStimulus(1'b1, I_ADD, 1'b1, 1'b0, 27'd0, "idle_run");

        // add r3,r1,r2, back-to-back into ld with delayed memory
        aluInstr(I_ADD, 1'b0, 4'd0, 1'b1);
        fetch(I_LD, 3);
        applyStimulus(1'b1, I_LD, 1'b1, 1'b0, E_B3, "ld_T3");
        applyStimulus(1'b1, I_LD, 1'b1, 1'b0, COUT | ZIN | alu(4'd0), "ld_T4");
        applyStimulus(1'b1, I_LD, 1'b1, 1'b0, E_A5, "ld_T5");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, I_LD, 1'b1, i == 3, READ | MEMSRC | MDRIN, "ld_T6");
        applyStimulus(1'b1, I_LD, 1'b1, 1'b0, MDROUT | GRA | RIN, "ld_T7");

        // st with write held for three cycles
        fetch(I_ST, 0);
        applyStimulus(1'b1, I_ST, 1'b1, 1'b0, E_B3, "st_T3");
        applyStimulus(1'b1, I_ST, 1'b1, 1'b0, COUT | ZIN | alu(4'd0), "st_T4");
        applyStimulus(1'b1, I_ST, 1'b1, 1'b0, E_A5, "st_T5");
        applyStimulus(1'b1, I_ST, 1'b1, 1'b0, GRA | ROUT | MDRIN, "st_T6");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, I_ST, 1'b1, i == 2, WRITE, "st_T7");

        // Remaining ALU flavours, ldi, nop and an unknown opcode
        aluInstr(I_SUB, 1'b0, 4'd1, 1'b1);
        aluInstr(I_OR, 1'b0, 4'd3, 1'b1);
        aluInstr(I_ANDI, 1'b1, 4'd2, 1'b1);
        aluInstr(I_ORI, 1'b1, 4'd3, 1'b1);
        fetch(I_LDI, 0);
        applyStimulus(1'b1, I_LDI, 1'b1, 1'b0, E_B3, "ldi_T3");
        applyStimulus(1'b1, I_LDI, 1'b1, 1'b0, COUT | ZIN | alu(4'd0), "ldi_T4");
        applyStimulus(1'b1, I_LDI, 1'b1, 1'b0, E_WB5, "ldi_T5");
        fetch(I_NOP, 0);
        applyStimulus(1'b1, I_NOP, 1'b1, 1'b0, 27'd0, "nop_T3");
        fetch(I_BAD, 0);
        applyStimulus(1'b1, I_BAD, 1'b1, 1'b0, ILLEGAL, "illegal_T3");

        // run dropped mid-instruction: addi completes, then IDLE
        fetch(I_ADDI, 0);
        applyStimulus(1'b1, I_ADDI, 1'b0, 1'b0, E_R3, "addi_T3");
        applyStimulus(1'b1, I_ADDI, 1'b0, 1'b0, COUT | ZIN | alu(4'd0), "addi_T4");
        applyStimulus(1'b1, I_ADDI, 1'b0, 1'b0, E_WB5, "addi_T5");
        applyStimulus(1'b1, I_ADDI, 1'b0, 1'b0, 27'd0, "idle_after_run_low");
        applyStimulus(1'b1, I_ADD, 1'b1, 1'b0, 27'd0, "idle_rerun");

        // Reset asserted during T4 of add, then restart at T0
        fetch(I_ADD, 0);
        applyStimulus(1'b1, I_ADD, 1'b1, 1'b0, E_R3, "add_T3");
        applyStimulus(1'b0, I_ADD, 1'b1, 1'b0, 27'd0, "reset_in_T4");
        applyStimulus(1'b1, I_ADD, 1'b1, 1'b0, 27'd0, "reset_release_idle");
        aluInstr(I_ADD, 1'b0, 4'd0, 1'b1);

        // Memory never answers during fetch: 16 read cycles, then HALT with mem_err
        applyStimulus(1'b1, I_LD, 1'b1, 1'b0, E_T0, "to_T0");
        applyStimulus(1'b1, I_LD, 1'b1, 1'b0, E_T1F, "to_T1_first");
        for (int i = 0; i < 15; i++)
            applyStimulus(1'b1, I_LD, 1'b1, 1'b0, E_T1W, "to_T1_wait");
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, I_LD, 1'b1, 1'b0, HALTED | MEMERR, "timeout_halt");
        applyStimulus(1'b0, I_LD, 1'b1, 1'b0, 27'd0, "reset_clears_err");
        applyStimulus(1'b1, I_HALT, 1'b1, 1'b0, 27'd0, "idle_before_halt");

        // halt opcode: HALT is absorbing even with run high
        fetch(I_HALT, 0);
        applyStimulus(1'b1, I_HALT, 1'b1, 1'b0, 27'd0, "halt_T3");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, I_HALT, 1'b1, 1'b1, HALTED, "halt_stays");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            check_count++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
